// File: rtl/maj_seq_eval_if.sv
// Host-side bus of the majority-network evaluator: program writes, run control, and results.
interface maj_seq_eval_if;
  logic         cfg_we;
  logic [2:0]   cfg_addr;
  logic [14:0]  cfg_data;
  logic         start;
  logic         single;
  logic [6:0]   vec_in;
  logic         busy;
  logic         done;
  logic         f_out;
  logic [127:0] tt;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, single, vec_in,
    input  busy, done, f_out, tt
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, single, vec_in,
    output busy, done, f_out, tt
  );
endinterface

// File: rtl/maj_seq_eval.sv
// Time-multiplexed MAJ3 network evaluator: one program node per cycle, either a single
// vector or a full 128-vector truth-table sweep.
module maj_seq_eval #(
  parameter int unsigned NODES = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  maj_seq_eval_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StEval, StDone} state_e;

  localparam logic [2:0] LastK  = 3'(NODES - 1);
  localparam logic [3:0] NodesW = 4'(NODES);

  state_e       state_q, state_d;
  logic [14:0]  prog_q [8];
  logic [7:0]   node_q;
  logic [2:0]   k_q;
  logic [6:0]   v_q;
  logic         single_q;
  logic [127:0] tt_q;
  logic         f_q;

  logic        accept;
  logic        last;
  logic [14:0] instr;
  logic        opa, opb, opc, res;

  // Operand {inv, sel}: x0..x6, constant 0, or node register (out-of-range index reads 0).
  function automatic logic operand(input logic [4:0] op, input logic [6:0] v,
                                   input logic [7:0] n);
    logic val;
    if (op[3]) begin
      val = ({1'b0, op[2:0]} < NodesW) ? n[op[2:0]] : 1'b0;
    end else if (op[2:0] == 3'd7) begin
      val = 1'b0;
    end else begin
      val = v[op[2:0]];
    end
    return val ^ op[4];
  endfunction

  assign accept = (state_q == StIdle) && bus.start;
  assign last   = (k_q == LastK);
  assign instr  = prog_q[k_q];
  assign opa    = operand(instr[4:0], v_q, node_q);
  assign opb    = operand(instr[9:5], v_q, node_q);
  assign opc    = operand(instr[14:10], v_q, node_q);
  assign res    = (opa & opb) | (opa & opc) | (opb & opc);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.start) state_d = StEval;
      StEval: if (last && (single_q || v_q == 7'h7f)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q   <= '0;
      k_q      <= '0;
      v_q      <= '0;
      single_q <= 1'b0;
      tt_q     <= '0;
      f_q      <= 1'b0;
    end else if (accept) begin
      single_q <= bus.single;
      k_q      <= '0;
      node_q   <= '0;
      if (bus.single) begin
        v_q <= bus.vec_in;
      end else begin
        v_q  <= '0;
        tt_q <= '0;
      end
    end else if (state_q == StEval) begin
      if (last) begin
        // Node registers clear between vectors so forward references never see stale data.
        k_q    <= '0;
        node_q <= '0;
        if (single_q) begin
          f_q <= res;
        end else begin
          tt_q[v_q] <= res;
          v_q       <= v_q + 7'd1;
        end
      end else begin
        k_q         <= k_q + 3'd1;
        node_q[k_q] <= res;
      end
    end
  end

  // Program RAM keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && (state_q != StEval) && !accept) begin
      prog_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  assign bus.busy  = (state_q == StEval);
  assign bus.done  = (state_q == StDone);
  assign bus.f_out = f_q;
  assign bus.tt    = tt_q;

endmodule

// File: doc/maj_seq_eval.md
# maj_seq_eval

Time-multiplexed evaluator for programmable 3-input majority networks over 7 inputs. It owns a single shared MAJ3 unit and a node program RAM, and evaluates one node per cycle in program order. In sweep mode it walks all 128 input vectors and assembles the network's full 128-bit truth table. In single mode it evaluates one vector. It sits between the classification host, which loads programs and reads signatures, and the majority-network datapath it replaces.

## Interface
- NODES, 6, number of program nodes evaluated per vector (1..8); output is node NODES-1
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  program write strobe (ignored while busy)
- cfg_addr  in  3  node index written
- cfg_data  in  15  operand A = [4:0], B = [9:5], C = [14:10]; each operand is {inv, sel[3:0]}
- start  in  1  one-cycle start pulse (ignored while busy)
- single  in  1  sampled with start: 1 = evaluate vec_in only, 0 = full 128-vector sweep
- vec_in  in  7  input vector for single mode; bit i = x_i
- busy  out  1  high from accepted start through the last evaluation cycle
- done  out  1  one-cycle pulse at completion
- f_out  out  1  single-mode result, held until the next start
- tt  out  128  sweep result: tt[v] = f(v), where v bit i = x_i; held until the next sweep start

## Operation
- Operand select sel: 0..6 selects x0..x6; 7 selects constant 0; 8..15 selects node register (sel-8). inv XORs the selected value. sel=7 with inv=1 yields constant 1.
- Node index (sel-8) >= NODES reads 0.
- Node registers n[0..7] clear to 0 at the start of every vector. A forward reference (node index >= current node) therefore reads 0. It never reads a stale value from the previous vector.
- Each EVAL cycle computes n[k] <= MAJ(A,B,C) for the current node k.
- States and transitions:
  - IDLE -> EVAL on start.
  - In EVAL, k counts 0..NODES-1. At k = NODES-1:
    - sweep mode: tt[v] <= result. If v = 127, go to DONE. Otherwise v increments, k returns to 0, and node registers clear.
    - single mode: f_out <= result, then go to DONE.
  - DONE -> IDLE unconditionally. done = 1 during DONE.
- Sweep start clears tt to 0 and sets v = 0. Single start sets v = vec_in and leaves tt untouched.
- cfg_we while busy is dropped, with no side effect. A program write in the same cycle as an accepted start is also dropped.
- start while busy is ignored.
- Program RAM is not cleared by reset. Its contents after reset are undefined until written.
- Reset asserted mid-run aborts immediately. No done pulse is produced.

## Timing
- Reset values: busy=0, done=0, f_out=0, tt=0, state=IDLE, k=0, v=0, node registers 0.
- Start is sampled at edge t. The first EVAL cycle is t+1, and busy rises at t+1.
- Sweep: EVAL occupies 128*NODES cycles. done is high in cycle t+1+128*NODES. busy falls in that same cycle. With NODES=6, done is at t+769.
- Single: done is at t+1+NODES. f_out is valid in the done cycle.
- tt[v] becomes visible the cycle after the last-node evaluation for vector v.
- Back-to-back runs: a start presented in the DONE cycle is ignored. The earliest accepted restart is the cycle after done.
- Throughput: one MAJ3 evaluation per cycle, with no bubbles between vectors.

## Test plan
- Program 6 nodes as (1,2,5), (4,6,8), (0,1,5), (0,3,9), (1,4,10), (2,11,12), all inv=0, then run a sweep:
  - done arrives 769 cycles after start.
  - tt = 128'hfeeafce8_fce8e880_fee8e8c0_e8c0a880.
- Same program in single mode:
  - vec_in=7'h07 -> f_out=1, done at start+7.
  - vec_in=7'h03 -> f_out=0.
  - vec_in=7'h7f -> f_out=1.
- Constants: NODES=1, node0 = {inv=1,sel=7}, {0,7}, {0,0}:
  - sweep -> tt[v] = x0, i.e. tt = 128'haaaa...aaaa.
  - Change node0 to three copies of {1,7} -> tt = all ones.
- Forward reference and out-of-range: NODES=2, node0 = (8,9,0), node1 = (0,0,0):
  - node0 evaluates to 0 for every vector.
  - tt = x0 pattern 128'haaaa...aaaa.
  - sel=15 with NODES=2 reads 0.
- Busy protection: during a sweep, pulse start and cfg_we with new data:
  - run length is unchanged and tt is unchanged.
  - program readback, via a subsequent run, shows the old contents.
- Reset mid-sweep (v≈50):
  - busy, done and tt return to 0 asynchronously and no done pulse occurs.
  - a following sweep produces the correct tt.
